// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core.
// Also performs EX-stage operand forwarding from the EX/MEM and MEM/WB stages.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic                        valid_i,
    input  logic [ALU_OP_WIDTH-1:0]     alu_op_i,
    input  logic                        alu_src_i,
    input  logic                        a_src_i,
    input  logic                        reg_write_i,
    input  logic                        mem_write_i,
    input  logic                        mem_to_reg_i,
    input  logic [REG_ADDR_WIDTH-1:0]   rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0]   rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [DATA_WIDTH-1:0]       rs1_data_i,
    input  logic [DATA_WIDTH-1:0]       rs2_data_i,
    input  logic [DATA_WIDTH-1:0]       imm_i,
    input  logic [DATA_WIDTH-1:0]       pc_i,
    input  logic                        exmem_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0]   exmem_rd_i,
    input  logic [DATA_WIDTH-1:0]       exmem_result_i,
    input  logic                        memwb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0]   memwb_rd_i,
    input  logic [DATA_WIDTH-1:0]       memwb_result_i,
    output logic                        valid_o,
    output logic [ALU_OP_WIDTH-1:0]     alu_op_o,
    output logic signed [DATA_WIDTH-1:0] alu_a_o,
    output logic signed [DATA_WIDTH-1:0] alu_b_o,
    output logic [DATA_WIDTH-1:0]       store_data_o,
    output logic [REG_ADDR_WIDTH-1:0]   rd_addr_o,
    output logic                        reg_write_o,
    output logic                        mem_write_o,
    output logic                        mem_to_reg_o,
    output logic [DATA_WIDTH-1:0]       pc_o,
    output logic [1:0]                  fwd_a_o,
    output logic [1:0]                  fwd_b_o
);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    logic                      valid_reg;
    logic [ALU_OP_WIDTH-1:0]   alu_op_reg;
    logic                      alu_src_reg;
    logic                      a_src_reg;
    logic                      reg_write_reg;
    logic                      mem_write_reg;
    logic                      mem_to_reg_reg;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_reg;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_reg;
    logic [DATA_WIDTH-1:0]     rs1_data_reg;
    logic [DATA_WIDTH-1:0]     rs2_data_reg;
    logic [DATA_WIDTH-1:0]     imm_reg;
    logic [DATA_WIDTH-1:0]     pc_reg;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_reg      <= 1'b0;
            alu_op_reg     <= '0;
            alu_src_reg    <= 1'b0;
            a_src_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            rs1_addr_reg   <= '0;
            rs2_addr_reg   <= '0;
            rd_addr_reg    <= '0;
            rs1_data_reg   <= '0;
            rs2_data_reg   <= '0;
            imm_reg        <= '0;
            pc_reg         <= '0;
        end else if (!stall_i) begin
            // A non-valid slot keeps its operands but can never cause side effects.
            valid_reg      <= valid_i;
            alu_op_reg     <= alu_op_i;
            alu_src_reg    <= alu_src_i;
            a_src_reg      <= a_src_i;
            reg_write_reg  <= valid_i & reg_write_i;
            mem_write_reg  <= valid_i & mem_write_i;
            mem_to_reg_reg <= valid_i & mem_to_reg_i;
            rs1_addr_reg   <= rs1_addr_i;
            rs2_addr_reg   <= rs2_addr_i;
            rd_addr_reg    <= rd_addr_i;
            rs1_data_reg   <= rs1_data_i;
            rs2_data_reg   <= rs2_data_i;
            imm_reg        <= imm_i;
            pc_reg         <= pc_i;
        end
    end

    // Index 0 is operand A (rs1), index 1 is operand B (rs2).
    logic [REG_ADDR_WIDTH-1:0] src_addr [2];
    logic [DATA_WIDTH-1:0]     src_data [2];
    logic [1:0]                fwd_sel  [2];
    logic [DATA_WIDTH-1:0]     fwd_data [2];

    assign src_addr[0] = rs1_addr_reg;
    assign src_addr[1] = rs2_addr_reg;
    assign src_data[0] = rs1_data_reg;
    assign src_data[1] = rs2_data_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic exmem_hit;
            logic memwb_hit;

            // x0 is hard-wired zero, so a write to it must never be forwarded.
            assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr[gi]);
            assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr[gi]);

            assign fwd_sel[gi]  = exmem_hit ? FWD_EXMEM :
                                  memwb_hit ? FWD_MEMWB : FWD_REGFILE;
            assign fwd_data[gi] = exmem_hit ? exmem_result_i :
                                  memwb_hit ? memwb_result_i : src_data[gi];
        end
    endgenerate

    assign valid_o      = valid_reg;
    assign alu_op_o     = alu_op_reg;
    assign alu_a_o      = a_src_reg   ? pc_reg  : fwd_data[0];
    assign alu_b_o      = alu_src_reg ? imm_reg : fwd_data[1];
    assign store_data_o = fwd_data[1];
    assign rd_addr_o    = rd_addr_reg;
    assign reg_write_o  = reg_write_reg & valid_reg;
    assign mem_write_o  = mem_write_reg & valid_reg;
    assign mem_to_reg_o = mem_to_reg_reg;
    assign pc_o         = pc_reg;
    assign fwd_a_o      = fwd_sel[0];
    assign fwd_b_o      = fwd_sel[1];

endmodule
